// File: rtl/fabric_config_loader.sv
// Streams host words into the fabric configuration shift chain and returns the
// bits shifted out of the chain as packed readback words.
module fabric_config_loader #(
  parameter int CHAIN_LEN = 1480,
  parameter int WORD_W    = 8,
  parameter int CLK_HALF  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [WORD_W-1:0] rb_data,
  output logic              rb_valid,
  input  logic              rb_ready,
  output logic              busy,
  output logic              done,
  output logic              prog_in,
  output logic              prog_clk,
  output logic              prog_en,
  input  logic              prog_out
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = $clog2(WORD_W + 1);
  localparam int PW = $clog2(CLK_HALF + 1);

  localparam logic [CW-1:0] LAST_BIT = CW'(CHAIN_LEN);
  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_W);
  localparam logic [PW-1:0] LAST_PH  = PW'(CLK_HALF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LO    = 3'd2,
    S_HI    = 3'd3,
    S_RB    = 3'd4,
    S_DONE  = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [IW-1:0]     bit_idx_q, bit_idx_d;
  logic [PW-1:0]     phase_q, phase_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [WORD_W-1:0] shreg_shift;
  logic [WORD_W-1:0] rb_data_q, rb_data_d;
  logic              wr_ready_q, wr_ready_d;
  logic              rb_valid_q, rb_valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              prog_in_q, prog_in_d;
  logic              prog_clk_q, prog_clk_d;
  logic              prog_en_q, prog_en_d;

  assign shreg_shift = shreg_q >> 1;

  // Next-state and next-output computation for the load sequencer.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    bit_idx_d  = bit_idx_q;
    phase_d    = phase_q;
    shreg_d    = shreg_q;
    rb_data_d  = rb_data_q;
    wr_ready_d = wr_ready_q;
    rb_valid_d = rb_valid_q;
    busy_d     = busy_q;
    done_d     = done_q;
    prog_in_d  = prog_in_q;
    prog_clk_d = prog_clk_q;
    prog_en_d  = prog_en_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          bit_cnt_d  = '0;
          bit_idx_d  = '0;
          busy_d     = 1'b1;
          wr_ready_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_FETCH: begin
        if (wr_valid) begin
          state_d    = S_LO;
          shreg_d    = wr_data;
          rb_data_d  = '0;
          phase_d    = '0;
          wr_ready_d = 1'b0;
          prog_in_d  = wr_data[0];
          prog_en_d  = 1'b1;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_LO: begin
        // prog_out is captured before this bit's rising edge moves the chain.
        for (int i = 0; i < WORD_W; i++) begin
          if ((phase_q == '0) && (bit_idx_q == IW'(i))) begin
            rb_data_d[i] = prog_out;
          end else begin
            rb_data_d[i] = rb_data_q[i];
          end
        end
        if (phase_q == LAST_PH) begin
          state_d    = S_HI;
          phase_d    = '0;
          prog_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_HI: begin
        if (phase_q == LAST_PH) begin
          phase_d    = '0;
          prog_clk_d = 1'b0;
          bit_idx_d  = bit_idx_q + IW'(1);
          bit_cnt_d  = bit_cnt_q + CW'(1);
          shreg_d    = shreg_shift;
          if (((bit_idx_q + IW'(1)) == LAST_IDX) || ((bit_cnt_q + CW'(1)) == LAST_BIT)) begin
            state_d    = S_RB;
            rb_valid_d = 1'b1;
          end else begin
            state_d   = S_LO;
            prog_in_d = shreg_shift[0];
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end

      S_RB: begin
        if (rb_ready) begin
          rb_valid_d = 1'b0;
          if (bit_cnt_q == LAST_BIT) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            busy_d    = 1'b0;
            prog_en_d = 1'b0;
          end else begin
            state_d    = S_FETCH;
            bit_idx_d  = '0;
            wr_ready_d = 1'b1;
          end
        end else begin
          state_d = S_RB;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
        done_d  = 1'b0;
      end

      default: begin
        state_d    = S_IDLE;
        wr_ready_d = 1'b0;
        rb_valid_d = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        prog_in_d  = 1'b0;
        prog_clk_d = 1'b0;
        prog_en_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      bit_idx_q  <= '0;
      phase_q    <= '0;
      shreg_q    <= '0;
      rb_data_q  <= '0;
      wr_ready_q <= 1'b0;
      rb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      prog_in_q  <= 1'b0;
      prog_clk_q <= 1'b0;
      prog_en_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      bit_idx_q  <= bit_idx_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      rb_data_q  <= rb_data_d;
      wr_ready_q <= wr_ready_d;
      rb_valid_q <= rb_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      prog_in_q  <= prog_in_d;
      prog_clk_q <= prog_clk_d;
      prog_en_q  <= prog_en_d;
    end
  end

  assign wr_ready = wr_ready_q;
  assign rb_data  = rb_data_q;
  assign rb_valid = rb_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign prog_in  = prog_in_q;
  assign prog_clk = prog_clk_q;
  assign prog_en  = prog_en_q;

endmodule

// File: tb/tb_fabric_config_loader.sv
// Table-driven bench for fabric_config_loader with a 20-bit behavioural chain
// (new bit enters at the top, chain[0] drives prog_out).
module tb_fabric_config_loader;

  localparam int CL = 20;
  localparam int WW = 8;
  localparam int CH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, wr_valid, rb_ready, prog_out;
  logic [WW-1:0] wr_data, rb_data;
  logic          wr_ready, rb_valid, busy, done, prog_in, prog_clk, prog_en;

  fabric_config_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CLK_HALF(CH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rb_data(rb_data), .rb_valid(rb_valid), .rb_ready(rb_ready),
    .busy(busy), .done(done),
    .prog_in(prog_in), .prog_clk(prog_clk), .prog_en(prog_en), .prog_out(prog_out)
  );

  logic [CL-1:0] chain = 20'hFFFFF;
  int rises = 0;
  assign prog_out = chain[0];

  always @(posedge prog_clk) begin
    chain <= {prog_in, chain[CL-1:1]};
    rises <= rises + 1;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Counts done pulses and prog_in changes near/within the prog_clk high phase.
  int   done_cnt = 0;
  int   viol = 0;
  logic pclk_prev = 1'b0, p1 = 1'b0, p2 = 1'b0, pin_rise = 1'b0;
  always @(negedge clk) begin
    if (done) done_cnt <= done_cnt + 1;
    if (prog_clk && !pclk_prev) begin
      if (prog_in !== p1 || prog_in !== p2) viol <= viol + 1;
      pin_rise <= prog_in;
    end else if (prog_clk && prog_in !== pin_rise) begin
      viol <= viol + 1;
    end
    p2 <= p1;
    p1 <= prog_in;
    pclk_prev <= prog_clk;
  end

  typedef struct {
    logic [23:0]   words;   // {w2, w1, w0}
    bit            stall;
    logic [23:0]   rb_exp;  // {rb2, rb1, rb0}
    logic [CL-1:0] chain_exp;
  } vec_t;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic run_load(input vec_t v, input string tag);
    logic [7:0] w [3];
    logic [7:0] r [3];
    int first_rdy, done_at, r0, d0, v0, stall_bad, n;
    w[0] = v.words[7:0];
    w[1] = v.words[15:8];
    w[2] = v.words[23:16];
    r[0] = 8'h00; r[1] = 8'h00; r[2] = 8'h00;
    r0 = rises; d0 = done_cnt; v0 = viol; stall_bad = 0; first_rdy = 0;
    rb_ready = !v.stall;
    wr_valid = 1'b0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " start latency busy/wr_ready"}, {30'd0, busy, wr_ready}, 32'd3);
    for (int k = 0; k < 3; k++) begin
      wr_data  = w[k];
      wr_valid = !(v.stall && k == 1);
      n = 0;
      while (!wr_ready && n < 300) begin @(negedge clk); n++; end
      if (!wr_ready) begin timeout_fail({tag, " wr_ready"}); wr_valid = 1'b0; return; end
      if (k == 0) first_rdy = cyc;
      if (v.stall && k == 1) begin
        repeat (7) begin
          if (!(prog_clk == 1'b0 && prog_en == 1'b1 && wr_ready == 1'b1)) stall_bad++;
          @(negedge clk);
        end
        wr_valid = 1'b1;
      end
      @(negedge clk); wr_valid = 1'b0;
      if (k == 0) begin
        start = 1'b1;
        @(negedge clk); start = 1'b0;
      end
      n = 0;
      while (!rb_valid && n < 300) begin @(negedge clk); n++; end
      if (!rb_valid) begin timeout_fail({tag, " rb_valid"}); return; end
      r[k] = rb_data;
      if (v.stall && k == 0) begin
        repeat (5) begin
          if (!(rb_valid && rb_data == r[k] && !prog_clk && prog_en)) stall_bad++;
          @(negedge clk);
        end
        rb_ready = 1'b1;
      end
      @(negedge clk);
    end
    n = 0;
    while (!done && n < 10) begin @(negedge clk); n++; end
    if (!done) begin timeout_fail({tag, " done"}); return; end
    done_at = cyc;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, " start at done ignored"}, {29'd0, busy, wr_ready, done}, 32'd0);
    rb_ready = 1'b0;
    chk({tag, " rb0"}, {24'd0, r[0]}, {24'd0, v.rb_exp[7:0]});
    chk({tag, " rb1"}, {24'd0, r[1]}, {24'd0, v.rb_exp[15:8]});
    chk({tag, " rb2"}, {24'd0, r[2]}, {24'd0, v.rb_exp[23:16]});
    chk({tag, " chain"}, {12'd0, chain}, {12'd0, v.chain_exp});
    chk({tag, " prog_clk rises"}, rises - r0, 32'd20);
    chk({tag, " done pulses"}, done_cnt - d0, 32'd1);
    chk({tag, " prog_in setup/hold"}, viol - v0, 32'd0);
    if (v.stall) chk({tag, " stall hold"}, stall_bad, 32'd0);
    else         chk({tag, " load time"}, done_at - first_rdy, 32'd86);
  endtask

  vec_t vecs [5];
  vec_t fresh;
  int   bad, r0, n;

  initial begin
    vecs[0] = '{words: 24'h0F3CA5, stall: 1'b0, rb_exp: 24'h0FFFFF, chain_exp: 20'hF3CA5};
    vecs[1] = '{words: 24'h0FFFFF, stall: 1'b0, rb_exp: 24'h0F3CA5, chain_exp: 20'hFFFFF};
    vecs[2] = '{words: 24'hF33412, stall: 1'b0, rb_exp: 24'h0FFFFF, chain_exp: 20'h33412};
    vecs[3] = '{words: 24'h0F3CA5, stall: 1'b1, rb_exp: 24'h033412, chain_exp: 20'hF3CA5};
    vecs[4] = '{words: 24'h0F3CA5, stall: 1'b0, rb_exp: 24'h0F3CA5, chain_exp: 20'hF3CA5};
    fresh   = '{words: 24'h06C35A, stall: 1'b0, rb_exp: 24'h052F9E, chain_exp: 20'h6C35A};

    rst_n = 1'b0; start = 1'b0; wr_valid = 1'b0; rb_ready = 1'b0; wr_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset outputs", {16'd0, wr_ready, rb_valid, busy, done, prog_in, prog_clk, prog_en, 1'b0, rb_data},
        32'd0);
    rst_n = 1'b1;
    r0 = rises;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if ({wr_ready, rb_valid, busy, done, prog_in, prog_clk, prog_en} !== 7'd0 || rb_data !== 8'h00) bad++;
    end
    chk("reset idle outputs", bad, 32'd0);
    chk("reset idle prog_clk rises", rises - r0, 32'd0);

    for (int i = 0; i < 5; i++) begin
      run_load(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset after nine bits of a load, then reload from scratch.
    r0 = rises;
    rb_ready = 1'b1; wr_data = 8'hA5; wr_valid = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    while (!wr_ready && n < 50) begin @(negedge clk); n++; end
    @(negedge clk); wr_data = 8'h3C;
    n = 0;
    while ((rises - r0) < 9 && n < 300) begin @(negedge clk); n++; end
    chk("midload rises before reset", rises - r0, 32'd9);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midload reset outputs", {16'd0, wr_ready, rb_valid, busy, done, prog_in, prog_clk, prog_en, 1'b0, rb_data},
        32'd0);
    rst_n = 1'b1; wr_valid = 1'b0; rb_ready = 1'b0;
    @(negedge clk);
    chk("midload idle after reset", {29'd0, busy, wr_ready, prog_en}, 32'd0);
    chk("midload chain", {12'd0, chain}, {12'd0, 20'h52F9E});
    run_load(fresh, "fresh");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
